fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Controller that sequences the 64-tap multiply-accumulate datapath for one output sample of the 16-bit FIR.
- Accepts input samples over a valid/ready handshake and stores them in an internal 64-entry circular delay line.
- Drives an external synchronous coefficient ROM.
- Streams 64 aligned (sample, coefficient) pairs to the MAC unit with enable/first/last qualifiers.
- Waits for the MAC unit's done pulse before accepting the next sample.

Parameters:
TAPS, 64, number of taps and delay-line depth (power of two)
AW, 6, log2(TAPS); width of tap index, pointers and coefficient address
DW, 16, sample and coefficient width
WAIT_MAX, 16, maximum cycles to wait for alu_done before flagging a timeout

Ports:
clk2  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_data  in  DW  input sample
s_ready  out  1  block can accept a sample (high only in IDLE)
coef_addr  out  AW  coefficient ROM address; ROM returns data one cycle later
coef_data  in  DW  coefficient ROM read data
mac_en  out  1  pair on mac_x/mac_c is valid this cycle
mac_x  out  DW  delay-line sample for current tap
mac_c  out  DW  coefficient for current tap
mac_first  out  1  with mac_en: tap 0 of the frame
mac_last  out  1  with mac_en: tap TAPS-1 of the frame
alu_done  in  1  single-cycle completion pulse from the MAC unit
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse when a frame completes normally
timeout_err  out  1  sticky; set when alu_done is not seen within WAIT_MAX cycles

Behaviour:
- Reset (async, rstn low) forces all outputs and state to their reset values:
  - s_ready=0 during reset, then 1 after release.
  - All other outputs 0; delay line cleared to 0; wr_ptr=0; tap counter=0; state=IDLE.
  - Reset mid-frame abandons the frame, with no frame_done.
- State IDLE:
  - s_ready=1.
  - On s_valid&s_ready at edge E0: mem[wr_ptr]<=s_data, newest<=wr_ptr, wr_ptr<=wr_ptr+1 (mod TAPS), k<=0, state->ISSUE.
- State ISSUE, lasting TAPS cycles:
  - Each cycle: coef_addr=k; delay-line read index=(newest-k) mod TAPS, registered.
  - k increments each cycle.
  - After issuing k=TAPS-1, state->DRAIN.
- Issue/present pipeline, one stage:
  - The pair issued for tap k appears one cycle later: mac_x=mem[(newest-k)mod TAPS], mac_c=coef_data, mac_en=1.
  - mac_first=1 only with k=0; mac_last=1 only with k=TAPS-1.
  - mac_en is high for exactly TAPS consecutive cycles per frame (edges E0+2 … E0+TAPS+1), never otherwise.
  - mac_x/mac_c hold their last values when mac_en=0.
- State DRAIN, one cycle: the last pair is presented; state->WAIT.
- State WAIT:
  - Wait counter starts at 0 and increments each cycle.
  - If alu_done=1: frame_done pulses the next cycle; state->IDLE.
  - If the counter reaches WAIT_MAX-1 without alu_done: timeout_err<=1 (sticky until reset); state->IDLE; no frame_done.
- alu_done outside WAIT is ignored.
- s_valid while busy is backpressured (s_ready=0). The sample must be held by the source; none are dropped.
- Arithmetic:
  - Pointer and index arithmetic is AW-bit modulo (wrap-around).
  - The first TAPS-1 frames after reset read zeros for taps not yet written.
- Throughput: one sample per TAPS+3+(alu_done latency) cycles.
- busy=1 in ISSUE/DRAIN/WAIT.

Test Plan:
- Reset, then s_data=0x0001, ROM coef[k]=k, alu_done 3 cycles after mac_last -> 64 mac_en cycles; mac_c=0..63 in order; mac_x=1 at k=0, 0 elsewhere; mac_first/mac_last on first/last; frame_done once.
- Feed samples 1..65 back-to-back, s_valid held high -> s_ready low during each frame; frame 65 has mac_x(k)=65-k for k=0..63 (sample 1 overwritten at wrap).
- Hold alu_done low after a frame -> timeout_err=1 exactly WAIT_MAX cycles after entering WAIT; no frame_done; next sample still accepted and sequenced.
- Pulse alu_done during ISSUE, then never in WAIT -> pulse ignored; timeout path taken.
- Assert rstn low at tap 30 -> all outputs 0 immediately; after release, a new frame reads zeros for all taps except k=0.
- s_valid low for 10 cycles in IDLE -> mac_en, coef_addr and wr_ptr remain unchanged.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Sequencer for one FIR output sample: stores the incoming sample in a circular
// delay line, then streams TAPS (sample, coefficient) pairs to an external MAC.
module fir_mac_sequencer #(
  parameter int TAPS     = 64,
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int WAIT_MAX = 16
) (
  input  logic          clk2,
  input  logic          rstn,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          mac_en,
  output logic [DW-1:0] mac_x,
  output logic [DW-1:0] mac_c,
  output logic          mac_first,
  output logic          mac_last,
  input  logic          alu_done,
  output logic          busy,
  output logic          frame_done,
  output logic          timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;
  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] newest_q, newest_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          rdy_q;
  logic [DW-1:0] x_q, c_q;
  logic          en_q, first_q, last_q;
  logic          fdone_q, fdone_d;
  logic          terr_q, terr_d;
  logic [DW-1:0] mem_q [TAPS];

  logic          accept, issue, in_wait, wait_expired;
  logic [AW-1:0] rd_idx;

  // rdy_q keeps s_ready low while reset is held and for the release edge.
  assign accept       = (state_q == S_IDLE) && rdy_q && s_valid;
  assign issue        = (state_q == S_ISSUE);
  assign in_wait      = (state_q == S_WAIT);
  assign wait_expired = in_wait && !alu_done && (wcnt_q == WW'(WAIT_MAX - 1));
  assign rd_idx       = newest_q - k_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    newest_d = newest_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        newest_d = wr_ptr_q;
        k_d      = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        k_d = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      default: begin
        if (alu_done || wait_expired) state_d = S_IDLE;
        else                          wcnt_d  = wcnt_q + WW'(1);
      end
    endcase
    fdone_d = in_wait && alu_done;
    terr_d  = terr_q || wait_expired;
  end

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      wr_ptr_q <= '0;
      newest_q <= '0;
      wcnt_q   <= '0;
      rdy_q    <= 1'b0;
      x_q      <= '0;
      c_q      <= '0;
      en_q     <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      fdone_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      newest_q <= newest_d;
      wcnt_q   <= wcnt_d;
      rdy_q    <= 1'b1;
      en_q     <= issue;
      first_q  <= issue && (k_q == '0);
      last_q   <= issue && (k_q == AW'(TAPS - 1));
      fdone_q  <= fdone_d;
      terr_q   <= terr_d;
      if (issue) x_q <= mem_q[rd_idx];
      // ROM data is only valid while a pair is presented; keep it for the hold.
      if (en_q)  c_q <= coef_data;
    end
  end

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready     = (state_q == S_IDLE) && rdy_q;
  assign busy        = (state_q != S_IDLE);
  assign coef_addr   = k_q;
  assign mac_en      = en_q;
  assign mac_x       = x_q;
  assign mac_c       = en_q ? coef_data : c_q;
  assign mac_first   = first_q;
  assign mac_last    = last_q;
  assign frame_done  = fdone_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: ROM returns coef[k]=k, a responder
// drives alu_done, and a monitor logs every presented MAC pair.
module tb_fir_mac_sequencer;
  localparam int TAPS = 64, AW = 6, DW = 16, WAIT_MAX = 16;

  logic clk2 = 1'b0, rstn = 1'b0, s_valid = 1'b0, alu_done = 1'b0;
  logic [DW-1:0] s_data = '0, coef_data = '0;
  logic s_ready, mac_en, mac_first, mac_last, busy, frame_done, timeout_err;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] mac_x, mac_c;

  always #5 clk2 = ~clk2;
  always @(posedge clk2) coef_data <= DW'(coef_addr);

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk2(clk2), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .coef_addr(coef_addr), .coef_data(coef_data), .mac_en(mac_en), .mac_x(mac_x),
    .mac_c(mac_c), .mac_first(mac_first), .mac_last(mac_last), .alu_done(alu_done),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err));

  typedef struct { logic [DW-1:0] x, c; logic f, l; int cyc; } cap_t;
  cap_t cq[$];
  int cyc = 0, nfd = 0, fdcyc = 0, lastcyc = 0, tcyc = 0, bpv = 0;
  logic tprev = 1'b0;

  always @(negedge clk2) begin
    cap_t t;
    cyc++;
    if (mac_en) begin
      t.x = mac_x; t.c = mac_c; t.f = mac_first; t.l = mac_last; t.cyc = cyc;
      cq.push_back(t);
      if (mac_last) lastcyc = cyc;
    end
    if (frame_done) begin nfd++; fdcyc = cyc; end
    if (timeout_err && !tprev) tcyc = cyc;
    tprev = timeout_err;
    if (busy && s_ready) bpv++;
  end

  int done_dly = -1;
  bit spur = 1'b0;
  initial begin
    forever begin
      @(negedge clk2);
      if (mac_en && mac_first && spur) begin
        alu_done = 1'b1; @(negedge clk2); alu_done = 1'b0;
      end else if (mac_en && mac_last && done_dly >= 0) begin
        repeat (done_dly) @(negedge clk2);
        alu_done = 1'b1; @(negedge clk2); alu_done = 1'b0;
      end
    end
  end

  int nchk = 0, npass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {s_ready, mac_en, mac_first, mac_last, busy, frame_done, timeout_err,
            coef_addr, mac_x, mac_c};
  endfunction

  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    s_valid = 1'b1; s_data = v;
    while (!s_ready && n < 400) begin @(negedge clk2); #1; n++; end
    if (!s_ready) begin chk("send_ready", 0, 1); s_valid = 1'b0; return; end
    @(posedge clk2); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_caps(input int target);
    int n = 0;
    while (cq.size() < target && n < 6000) begin @(negedge clk2); #1; n++; end
    if (cq.size() < target) chk("wait_mac_en", cq.size(), target);
  endtask

  task automatic run_frame(input logic [DW-1:0] v, input int dly, input bit sp,
                           output int base, output int nfd0);
    done_dly = dly; spur = sp; base = cq.size(); nfd0 = nfd;
    send(v);
    wait_caps(base + TAPS);
    repeat (24) @(negedge clk2);
    #1;
  endtask

  // Pair order, qualifiers, contiguity and exact enable count of one frame.
  task automatic check_std(input string tag, input int base, input bit exact);
    int bad = 0;
    if (cq.size() < base + TAPS) begin chk({tag, "_avail"}, cq.size(), base + TAPS); return; end
    if (exact) chk({tag, "_en_cnt"}, cq.size() - base, TAPS);
    for (int k = 0; k < TAPS; k++)
      if (cq[base+k].c !== DW'(k) || cq[base+k].f !== (k == 0) || cq[base+k].l !== (k == TAPS-1))
        bad++;
    chk({tag, "_pairs"}, bad, 0);
    chk({tag, "_contig"}, cq[base+TAPS-1].cyc - cq[base].cyc, TAPS - 1);
  endtask

  function automatic int nonzero_tail(input int base);
    int n = 0;
    for (int k = 1; k < TAPS; k++) if (cq.size() > base + k && cq[base+k].x !== '0) n++;
    return n;
  endfunction

  typedef struct {
    logic [DW-1:0] sample; int dly;
    logic [DW-1:0] ex0, ex1; logic efd, eto; int elat;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int base, nfd0, bpv0, chg, bad, n, w;
    logic [AW-1:0] ca0;
    tbl[0] = '{16'h0002,  1, 16'h0002, 16'h0001, 1'b1, 1'b0,  2};
    tbl[1] = '{16'h8000,  5, 16'h8000, 16'h0002, 1'b1, 1'b0,  6};
    tbl[2] = '{16'hFFFF, 16, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 17};
    tbl[3] = '{16'h0ABC, -1, 16'h0ABC, 16'hFFFF, 1'b0, 1'b1, 17};

    repeat (3) @(negedge clk2);
    #1 chk("rst_outs", outs(), 64'h0);
    @(negedge clk2); rstn = 1'b1;
    @(negedge clk2); #1;
    chk("rdy_after_rst", {s_ready, busy}, 2'b10);

    run_frame(16'h0001, 3, 1'b0, base, nfd0);
    check_std("f1", base, 1'b1);
    chk("f1_x0", cq[base].x, 16'h0001);
    chk("f1_x_rest", nonzero_tail(base), 0);
    chk("f1_fd", nfd - nfd0, 1);
    chk("f1_fd_lat", fdcyc - lastcyc, 4);
    chk("f1_tout", timeout_err, 1'b0);

    ca0 = coef_addr; chg = 0;
    repeat (10) begin
      @(negedge clk2); #1;
      if (coef_addr !== ca0 || mac_en !== 1'b0 || s_ready !== 1'b1) chg++;
    end
    chk("idle_hold", chg, 0);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].sample, tbl[i].dly, 1'b0, base, nfd0);
      check_std($sformatf("v%0d", i), base, 1'b1);
      chk($sformatf("v%0d_x0", i), cq[base].x, tbl[i].ex0);
      chk($sformatf("v%0d_x1", i), cq[base+1].x, tbl[i].ex1);
      chk($sformatf("v%0d_x63", i), cq[base+TAPS-1].x, 16'h0);
      chk($sformatf("v%0d_fd", i), nfd - nfd0, tbl[i].efd);
      chk($sformatf("v%0d_tout", i), timeout_err, tbl[i].eto);
      chk($sformatf("v%0d_lat", i), tbl[i].efd ? fdcyc - lastcyc : tcyc - lastcyc, tbl[i].elat);
    end

    run_frame(16'h0007, 3, 1'b0, base, nfd0);
    check_std("post_to", base, 1'b1);
    chk("post_to_x01", {cq[base].x, cq[base+1].x}, {16'h0007, 16'h0ABC});
    chk("post_to_fd", nfd - nfd0, 1);
    chk("tout_sticky", timeout_err, 1'b1);

    @(negedge clk2); rstn = 1'b0;
    #1 chk("rst2_outs", outs(), 64'h0);
    @(negedge clk2); rstn = 1'b1;
    @(negedge clk2);
    run_frame(16'h0101, -1, 1'b1, base, nfd0);
    check_std("spur", base, 1'b1);
    chk("spur_x01", {cq[base].x, cq[base+1].x}, {16'h0101, 16'h0000});
    chk("spur_fd", nfd - nfd0, 0);
    chk("spur_tout", timeout_err, 1'b1);
    chk("spur_lat", tcyc - lastcyc, 17);

    done_dly = 3; spur = 1'b0; base = cq.size(); nfd0 = nfd;
    send(16'h1234);
    wait_caps(base + 31);
    rstn = 1'b0;
    #1 chk("midrst_outs", outs(), 64'h0);
    chk("midrst_tap", cq.size() - base, 31);
    repeat (2) @(negedge clk2);
    rstn = 1'b1;
    repeat (30) @(negedge clk2);
    #1 chk("midrst_no_fd", nfd - nfd0, 0);
    run_frame(16'h0055, 3, 1'b0, base, nfd0);
    check_std("after_rst", base, 1'b1);
    chk("after_rst_x0", cq[base].x, 16'h0055);
    chk("after_rst_zero", nonzero_tail(base), 0);
    chk("after_rst_fd", nfd - nfd0, 1);

    @(negedge clk2); rstn = 1'b0;
    @(negedge clk2); rstn = 1'b1;
    @(negedge clk2); #1;
    done_dly = 3; base = cq.size(); nfd0 = nfd; bpv0 = bpv;
    s_valid = 1'b1;
    for (int s = 1; s <= 65; s++) begin
      s_data = DW'(s); w = 0;
      while (!s_ready && w < 400) begin @(negedge clk2); #1; w++; end
      if (!s_ready) begin chk("b2b_ready", s, 0); break; end
      @(posedge clk2); #1;
    end
    s_valid = 1'b0;
    wait_caps(base + 65 * TAPS);
    repeat (24) @(negedge clk2);
    #1;
    chk("b2b_en_total", cq.size() - base, 65 * TAPS);
    chk("b2b_fd", nfd - nfd0, 65);
    chk("b2b_backpressure", bpv - bpv0, 0);
    if (cq.size() >= base + 65 * TAPS) begin
      bad = 0;
      for (int f = 0; f < 65; f++) if (cq[base + f*TAPS].x !== DW'(f + 1)) bad++;
      chk("b2b_x0_each", bad, 0);
      n = base + 64 * TAPS;
      check_std("b2b_f65", n, 1'b0);
      bad = 0;
      for (int k = 0; k < TAPS; k++) if (cq[n+k].x !== DW'(65 - k)) bad++;
      chk("b2b_f65_wrap", bad, 0);
      chk("b2b_period", cq[base + TAPS].cyc - cq[base].cyc, 69);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
